// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared widths and FSM state type for binary_line_buffer
package lb_pkg;
   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } lb_state_t;
endpackage

// File: rtl/lb_line_ram.sv
// rtl/lb_line_ram.sv - 1-bit line RAM, one write port, registered read-first read port
module lb_line_ram #(
   parameter int DEPTH = 320,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic          i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic          o_rdata
);
   logic r_mem [DEPTH];
   logic r_rdata;

   // Contents are deliberately not reset; the read sees the old word on a same-address write.
   always_ff @(posedge clk_in) begin
      if (i_re) r_rdata <= r_mem[i_raddr];
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/binary_line_buffer.sv
// rtl/binary_line_buffer.sv - two-line buffer emitting 3-bit vertical columns {y-2, y-1, y}
// Optional bottom-row flush is built when LB_FLUSH_EN is defined.
module binary_line_buffer
   import lb_pkg::*;
#(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                pixel_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                data_valid_in,
   output logic [2:0]          data_out,
   output logic [HCOUNT_W-1:0] hcount_out,
   output logic [VCOUNT_W-1:0] vcount_out,
   output logic                data_valid_out
);
   localparam int AW = $clog2(H_ACTIVE);
   localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);
   localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_ACTIVE - 1);

   lb_state_t r_state, w_next;

   logic                w_in_range, w_is_origin, w_accept, w_flush_active, w_re;
   logic                w_we0, w_we1, w_rd0, w_rd1, w_top, w_center;
   logic [HCOUNT_W-1:0] w_col;

   logic                r_vld1, r_pix1, r_sel1, r_top_zero1;
   logic [HCOUNT_W-1:0] r_h1;
   logic [VCOUNT_W-1:0] r_v1;

   assign w_in_range  = data_valid_in && (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
   assign w_is_origin = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
   assign w_accept    = (r_state == STREAM) ? w_in_range : w_is_origin;

`ifdef LB_FLUSH_EN
   logic [HCOUNT_W-1:0] r_flush_h;

   // A fresh origin pixel takes the RAMs over from the flush in the same cycle.
   assign w_flush_active = (r_state == FLUSH) && !w_is_origin;
   assign w_col          = w_flush_active ? r_flush_h : hcount_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                r_flush_h <= '0;
      else if (r_state != FLUSH) r_flush_h <= '0;
      else if (w_flush_active)   r_flush_h <= r_flush_h + 1'b1;
   end
`else
   assign w_flush_active = 1'b0;
   assign w_col          = hcount_in;
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_is_origin) w_next = STREAM;
         end
         STREAM: begin
`ifdef LB_FLUSH_EN
            if (w_accept && (hcount_in == H_LAST) && (vcount_in == V_LAST)) w_next = FLUSH;
`endif
         end
         FLUSH: begin
`ifdef LB_FLUSH_EN
            if (w_is_origin)              w_next = STREAM;
            else if (r_flush_h == H_LAST) w_next = IDLE;
`else
            w_next = IDLE;
`endif
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_re  = w_accept || w_flush_active;
   assign w_we0 = w_accept && !vcount_in[0];
   assign w_we1 = w_accept &&  vcount_in[0];

   lb_line_ram #(.DEPTH(H_ACTIVE), .AW(AW)) u_l0 (
      .clk_in  (clk_in),
      .i_we    (w_we0),
      .i_waddr (hcount_in[AW-1:0]),
      .i_wdata (pixel_in),
      .i_re    (w_re),
      .i_raddr (w_col[AW-1:0]),
      .o_rdata (w_rd0)
   );

   lb_line_ram #(.DEPTH(H_ACTIVE), .AW(AW)) u_l1 (
      .clk_in  (clk_in),
      .i_we    (w_we1),
      .i_waddr (hcount_in[AW-1:0]),
      .i_wdata (pixel_in),
      .i_re    (w_re),
      .i_raddr (w_col[AW-1:0]),
      .o_rdata (w_rd1)
   );

   // r_sel1 names the RAM holding the centre row; the other one holds the top row.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_vld1      <= 1'b0;
         r_pix1      <= 1'b0;
         r_sel1      <= 1'b0;
         r_top_zero1 <= 1'b0;
         r_h1        <= '0;
         r_v1        <= '0;
      end else begin
         r_vld1 <= (w_accept && (vcount_in != '0)) || w_flush_active;
         if (w_flush_active) begin
            r_pix1      <= 1'b0;
            r_sel1      <= V_LAST[0];
            r_top_zero1 <= 1'b0;
            r_h1        <= w_col;
            r_v1        <= V_LAST;
         end else if (w_accept) begin
            r_pix1      <= pixel_in;
            r_sel1      <= ~vcount_in[0];
            r_top_zero1 <= (vcount_in == VCOUNT_W'(1));
            r_h1        <= hcount_in;
            r_v1        <= vcount_in - 1'b1;
         end
      end
   end

   assign w_center = r_sel1 ? w_rd1 : w_rd0;
   assign w_top    = (r_sel1 ? w_rd0 : w_rd1) & ~r_top_zero1;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         data_out       <= '0;
         hcount_out     <= '0;
         vcount_out     <= '0;
         data_valid_out <= 1'b0;
      end else begin
         data_valid_out <= r_vld1;
         if (r_vld1) begin
            data_out   <= {w_top, w_center, r_pix1};
            hcount_out <= r_h1;
            vcount_out <= r_v1;
         end
      end
   end
endmodule
